// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback path.
//  ADDR_SIZE   register address width (2**ADDR_SIZE registers)
//  DATA_WIDTH  register data width
//  wb_entry_t  one queued result: destination register + data
//  grant_t     which source the round-robin arbiter granted last
package wb_pkg;

    localparam int ADDR_SIZE  = 4;
    localparam int DATA_WIDTH = 16;
    localparam int NUM_REGS   = 1 << ADDR_SIZE;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_MEM = 1'b0,
        GRANT_ALU = 1'b1
    } grant_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of every non-clock signal of the writeback arbiter.
//  alu_* / mem_*   result sources (valid/addr/data in, ready out)
//  issue_*         destination reservation from issue
//  chk_addr_*      source-operand hazard lookups, busy_* answers
//  w_en/addr_c/data_c  register-file write port (registered)
//  dbg_last_grant  arbiter state, for observation only
//
// Handshake: a result transfers on a rising edge where valid and ready are
// both high. ready depends only on FIFO occupancy (never on valid), and a
// source holding valid must keep addr/data stable until the transfer.
interface writeback_arbiter_if;
    import wb_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_SIZE-1:0]  alu_addr;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  issue_en;
    logic [ADDR_SIZE-1:0]  issue_addr;
    logic [ADDR_SIZE-1:0]  chk_addr_a;
    logic [ADDR_SIZE-1:0]  chk_addr_b;
    logic                  busy_a;
    logic                  busy_b;
    logic                  w_en;
    logic [ADDR_SIZE-1:0]  addr_c;
    logic [DATA_WIDTH-1:0] data_c;
    grant_t                dbg_last_grant;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output issue_en, issue_addr, chk_addr_a, chk_addr_b,
        input  alu_ready, mem_ready, busy_a, busy_b,
        input  w_en, addr_c, data_c, dbg_last_grant
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  issue_en, issue_addr, chk_addr_a, chk_addr_b,
        output alu_ready, mem_ready, busy_a, busy_b,
        output w_en, addr_c, data_c, dbg_last_grant
    );

endinterface

// File: rtl/writeback_arbiter_fifo.sv
// Small circular FIFO holding pending writeback entries for one source.
//  clk, rst_n   clock, asynchronous active-low reset
//  push_i       source valid; accepted only while not full
//  push_data_i  entry to enqueue
//  pop_i        arbiter grant; ignored while empty
//  pop_data_o   head entry (valid while !empty_o)
//  empty_o      no entries queued
//  ready_o      not full; no push-through when full
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t pop_data_o,
    output logic      empty_o,
    output logic      ready_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign ready_o    = !full;
    assign do_push    = push_i && !full;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port and
// tracks destinations with a write still outstanding (busy bits).
//  clk   clock, rising edge
//  rst   asynchronous active-low reset
//  bus   writeback_arbiter_if.slave: source handshakes, issue/check ports,
//        registered write port and arbiter debug state
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                rst,
    writeback_arbiter_if.slave bus
);

    wb_entry_t alu_in, mem_in;
    wb_entry_t alu_head, mem_head;
    logic      alu_empty, mem_empty;
    logic      grant_alu, grant_mem;

    grant_t                last_grant_q, last_grant_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_SIZE-1:0]  addr_c_q, addr_c_d;
    logic [DATA_WIDTH-1:0] data_c_q, data_c_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    assign alu_in.addr = bus.alu_addr;
    assign alu_in.data = bus.alu_data;
    assign mem_in.addr = bus.mem_addr;
    assign mem_in.data = bus.mem_data;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (bus.alu_valid),
        .push_data_i (alu_in),
        .pop_i       (grant_alu),
        .pop_data_o  (alu_head),
        .empty_o     (alu_empty),
        .ready_o     (bus.alu_ready)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (bus.mem_valid),
        .push_data_i (mem_in),
        .pop_i       (grant_mem),
        .pop_data_o  (mem_head),
        .empty_o     (mem_empty),
        .ready_o     (bus.mem_ready)
    );

    // Round-robin: on contention the source not granted last time wins.
    // last_grant only moves on an actual grant.
    always_comb begin
        grant_alu    = 1'b0;
        grant_mem    = 1'b0;
        last_grant_d = last_grant_q;
        if (!alu_empty && !mem_empty) begin
            if (last_grant_q == GRANT_ALU) grant_mem = 1'b1;
            else                           grant_alu = 1'b1;
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end
        if (grant_alu)      last_grant_d = GRANT_ALU;
        else if (grant_mem) last_grant_d = GRANT_MEM;
    end

    // Write port: addr/data hold their last value when nothing is popped.
    always_comb begin
        w_en_d   = grant_alu || grant_mem;
        addr_c_d = addr_c_q;
        data_c_d = data_c_q;
        if (grant_alu) begin
            addr_c_d = alu_head.addr;
            data_c_d = alu_head.data;
        end else if (grant_mem) begin
            addr_c_d = mem_head.addr;
            data_c_d = mem_head.data;
        end
    end

    // A write clears its destination the edge after it appears on the port;
    // a new reservation on the same edge is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (w_en_q)       busy_d[addr_c_q]       = 1'b0;
        if (bus.issue_en) busy_d[bus.issue_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= GRANT_ALU;  // makes the load source first in line
            w_en_q       <= 1'b0;
            addr_c_q     <= '0;
            data_c_q     <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            w_en_q       <= w_en_d;
            addr_c_q     <= addr_c_d;
            data_c_q     <= data_c_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.w_en           = w_en_q;
    assign bus.addr_c         = addr_c_q;
    assign bus.data_c         = data_c_q;
    assign bus.busy_a         = busy_q[bus.chk_addr_a];
    assign bus.busy_b         = busy_q[bus.chk_addr_b];
    assign bus.dbg_last_grant = last_grant_q;

endmodule
